// File: rtl/instruction_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher.
// Holds the field widths and the dispatcher FSM state type.
package instruction_dispatcher_pkg;

    localparam int INSTR_W = 45;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: a circular buffer with a registered occupancy count and a
// registered read port.
// Ports:
//   clk, srst              clock, synchronous active-high reset
//   push_valid, push_data  write request; it is ignored while the FIFO is full
//   push_ready             the FIFO is not full (taken from count only)
//   pop                    takes the head entry into pop_data (ignored when empty)
//   pop_data               the last popped entry; it holds until the next pop
//   count                  occupancy 0..DEPTH
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 45
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ready,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (count_reg < DEPTH_C);
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & (count_reg != '0);
    assign pop_data   = rd_data_reg;
    assign count      = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset. A clear count marks every entry as stale.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // The head slot is never the write target in the same cycle. It is either
    // already written, or the FIFO is full and the push is refused.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (do_pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher. It buffers host instructions and issues them one at
// a time to a PIM core. It then waits for the core to finish and returns the
// core's read data, tagged with an issue sequence number.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_instr/in_ready   host push interface (FIFO not full)
//   pim_instruction          instruction held for the core from ISSUE onwards
//   pim_operation_enable     one-cycle start strobe (the ISSUE state)
//   pim_ready, pim_data_out  core idle/done flag and core read data
//   res_valid/res_data/res_tag   one-cycle result strobe, data and sequence tag
//   timeout_err              sticky watchdog abort flag
//   idle                     the FSM is in IDLE and the FIFO is empty
module instruction_dispatcher
    import instruction_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [INSTR_W-1:0] pim_instruction,
    output logic               pim_operation_enable,
    input  logic               pim_ready,
    input  logic [DATA_W-1:0]  pim_data_out,
    output logic               res_valid,
    output logic [DATA_W-1:0]  res_data,
    output logic [TAG_W-1:0]   res_tag,
    output logic               timeout_err,
    output logic               idle
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t                    state_reg, state_next;
    logic [7:0]                wd_reg, wd_next;
    logic                      busy_seen_reg, busy_seen_next;
    logic [TAG_W-1:0]          seq_reg;
    logic                      res_valid_reg;
    logic [DATA_W-1:0]         res_data_reg;
    logic [TAG_W-1:0]          res_tag_reg;
    logic                      timeout_reg;
    logic                      fifo_pop;
    logic                      capture;
    logic                      abort;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk        (clk),
        .srst       (rst),
        .push_valid (in_valid),
        .push_data  (in_instr),
        .push_ready (in_ready),
        .pop        (fifo_pop),
        .pop_data   (pim_instruction),
        .count      (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        wd_next        = wd_reg;
        busy_seen_next = busy_seen_reg;
        fifo_pop       = 1'b0;
        capture        = 1'b0;
        abort          = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if ((fifo_count != '0) && pim_ready) begin
                    fifo_pop   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next     = WAIT_BUSY;
                wd_next        = '0;
                busy_seen_next = 1'b0;
            end
            WAIT_BUSY: begin
                wd_next = wd_reg + 8'd1;
                if (!pim_ready) begin
                    state_next = WAIT_DONE;
                end else if (busy_seen_reg) begin
                    // The core never dropped ready, so the operation was single-cycle.
                    state_next = CAPTURE;
                end else begin
                    busy_seen_next = 1'b1;
                end
            end
            WAIT_DONE: begin
                wd_next = wd_reg + 8'd1;
                if (pim_ready) state_next = CAPTURE;
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // wd_reg counts the wait cycles already spent. The TIMEOUT-th wait
        // cycle aborts unless it completes the operation.
        if (((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) &&
            (state_next != CAPTURE) && (wd_reg == WD_LAST)) begin
            abort      = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wd_reg        <= '0;
            busy_seen_reg <= 1'b0;
            seq_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_tag_reg   <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wd_reg        <= wd_next;
            busy_seen_reg <= busy_seen_next;
            res_valid_reg <= capture;
            if (capture) begin
                res_data_reg <= pim_data_out;
                res_tag_reg  <= seq_reg;
                seq_reg      <= seq_reg + TAG_W'(1);
            end
            if (abort) timeout_reg <= 1'b1;
        end
    end

    assign pim_operation_enable = (state_reg == ISSUE);
    assign res_valid            = res_valid_reg;
    assign res_data             = res_data_reg;
    assign res_tag              = res_tag_reg;
    assign timeout_err          = timeout_reg;
    assign idle                 = (state_reg == IDLE) && (fifo_count == '0);

endmodule
